alu_seq_ctrl: RTL and testbench

Synchronous operand-capture and execution sequencer for the 4-bit ALU datapath. It debounces the raw GO button and captures A on the first press and B on the second. It then drives registered operands and opcode into the combinational ALU, registers the ALU outputs, and drives the four status LEDs. It replaces edge-on-GO operand capture with fully clk-synchronous sequencing.

---
 rtl/alu_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Clock-synchronous operand-capture sequencer for the 4-bit ALU datapath.
// Debounces GO, captures A then B on successive presses, and registers the ALU outputs.
module alu_seq_ctrl #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned OPW       = 3,
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] data,
  input  logic [OPW-1:0]   opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_borrow,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             borrow,
  output logic             led_idle,
  output logic             led_wait,
  output logic             led_rdy,
  output logic             led_done
);

  localparam int unsigned CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_A_HELD = 3'd1,
    S_WAIT_B = 3'd2,
    S_B_HELD = 3'd3,
    S_EXEC   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_go_db;
  logic          r_go_db_q;
  logic [CW-1:0] r_db_cnt;
  logic          w_go_rise;
  logic          w_go_fall;
  logic          w_load_a;
  logic          w_load_b;
  logic          w_load_op;
  logic          w_load_res;

  // go_db flips on the edge that sees the DB_CYCLES-th consecutive differing sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_go_db   <= 1'b0;
      r_go_db_q <= 1'b0;
      r_db_cnt  <= '0;
    end else begin
      r_sync1   <= go;
      r_sync2   <= r_sync1;
      r_go_db_q <= r_go_db;
      if (r_sync2 != r_go_db) begin
        if (r_db_cnt == CW'(DB_CYCLES - 1)) begin
          r_go_db  <= r_sync2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  assign w_go_rise = r_go_db & ~r_go_db_q;
  assign w_go_fall = ~r_go_db & r_go_db_q;

  always_comb begin
    w_state_nxt = r_state;
    w_load_a    = 1'b0;
    w_load_b    = 1'b0;
    w_load_op   = 1'b0;
    w_load_res  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_go_rise) begin
          w_load_a    = 1'b1;
          w_state_nxt = S_A_HELD;
        end
      end
      S_A_HELD: begin
        if (w_go_fall) w_state_nxt = S_WAIT_B;
      end
      S_WAIT_B: begin
        if (w_go_rise) begin
          w_load_b    = 1'b1;
          w_state_nxt = S_B_HELD;
        end
      end
      S_B_HELD: begin
        if (w_go_fall) begin
          w_load_op   = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_load_res  = 1'b1;
        w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      result  <= '0;
      cout    <= 1'b0;
      borrow  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_a)  alu_a  <= data;
      if (w_load_b)  alu_b  <= data;
      if (w_load_op) alu_op <= opcode;
      if (w_load_res) begin
        result <= alu_result;
        cout   <= alu_cout;
        borrow <= alu_borrow;
      end
    end
  end

  always_comb begin
    led_idle = 1'b0;
    led_wait = 1'b0;
    led_rdy  = 1'b0;
    led_done = 1'b0;
    case (r_state)
      S_A_HELD, S_WAIT_B, S_B_HELD: led_wait = 1'b1;
      S_EXEC:                       led_rdy  = 1'b1;
      S_DONE:                       led_done = 1'b1;
      default:                      led_idle = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: behavioural ALU stub, table vectors,
// hand-written corner sequences and randomized operations against a reference model.
module tb_alu_seq_ctrl;

  logic       clk;
  logic       reset;
  logic       go;
  logic [3:0] data;
  logic [2:0] opcode;
  logic [3:0] alu_result;
  logic       alu_cout;
  logic       alu_borrow;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic [3:0] result;
  logic       cout;
  logic       borrow;
  logic       led_idle;
  logic       led_wait;
  logic       led_rdy;
  logic       led_done;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 0;

  logic [3:0] m_res;
  logic       m_c;
  logic       m_b;

  alu_seq_ctrl #(.WIDTH(4), .OPW(3), .DB_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .go(go), .data(data), .opcode(opcode),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_borrow(alu_borrow),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .result(result), .cout(cout), .borrow(borrow),
    .led_idle(led_idle), .led_wait(led_wait), .led_rdy(led_rdy), .led_done(led_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {borrow, cout, result} for the 4-bit ALU
  function automatic logic [5:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
    int s;
    case (op)
      3'd0: begin s = int'(a) + int'(b); return {1'b0, s >= 16, 4'(s)}; end
      3'd1: begin s = int'(a) - int'(b); return {s < 0, 1'b0, 4'(s)}; end
      3'd2: return {2'b00, ~a};
      3'd3: return {2'b00, ~b};
      3'd4: return {2'b00, a & b};
      3'd5: return {2'b00, a | b};
      3'd6: return {2'b00, a ^ b};
      default: return {2'b00, ~(a ^ b)};
    endcase
  endfunction

  always_comb {alu_borrow, alu_cout, alu_result} = ref_alu(alu_a, alu_b, alu_op);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ((32'(led_idle) + 32'(led_wait) + 32'(led_rdy) + 32'(led_done)) != 1) begin
        failures++;
        $display("FAIL onehot: got %b%b%b%b expected exactly one set",
                 led_idle, led_wait, led_rdy, led_done);
      end
    end
  end

  task automatic press_a(input logic [3:0] a);
    data = a;
    go   = 1'b1;
    cyc(10);
    chk("a_held_led", led_wait, 1'b1);
    chk("a_capt", alu_a, a);
    chk("a_res_hold", result, m_res);
    data   = 4'($urandom);
    opcode = 3'($urandom);
    go     = 1'b0;
    cyc(10);
    chk("wait_b_led", led_wait, 1'b1);
    chk("a_stable", alu_a, a);
  endtask

  task automatic press_b_exec(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                              input logic [3:0] er, input logic ec, input logic eb);
    int n;
    data = b;
    go   = 1'b1;
    cyc(10);
    chk("b_capt", alu_b, b);
    chk("b_res_hold", {borrow, cout, result}, {m_b, m_c, m_res});
    opcode = op;
    go     = 1'b0;
    cyc(1);
    data = 4'($urandom);
    n = 0;
    while (!led_rdy && n < 20) begin
      cyc(1);
      n++;
    end
    chk("exec_seen", led_rdy, 1'b1);
    chk("exec_res_old", result, m_res);
    chk("op_capt", alu_op, op);
    opcode = 3'($urandom);
    cyc(1);
    chk("done_led", led_done, 1'b1);
    chk("res", result, er);
    chk("cout", cout, ec);
    chk("borrow", borrow, eb);
    chk("a_final", alu_a, a);
    m_res = er;
    m_c   = ec;
    m_b   = eb;
    cyc(3);
    chk("done_hold", {led_done, borrow, cout, result}, {1'b1, eb, ec, er});
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        input logic [3:0] er, input logic ec, input logic eb);
    press_a(a);
    press_b_exec(a, b, op, er, ec, eb);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] res;
    logic       c;
    logic       bw;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [5:0] e;
    logic [3:0] ra, rb;
    logic [2:0] rop;

    tbl[0] = '{4'd9,  4'd8,  3'd0, 4'd1,  1'b1, 1'b0};
    tbl[1] = '{4'd3,  4'd5,  3'd1, 4'd14, 1'b0, 1'b1};
    tbl[2] = '{4'd12, 4'd10, 3'd6, 4'd6,  1'b0, 1'b0};
    tbl[3] = '{4'd10, 4'd0,  3'd2, 4'd5,  1'b0, 1'b0};
    tbl[4] = '{4'd12, 4'd10, 3'd4, 4'd8,  1'b0, 1'b0};
    tbl[5] = '{4'd12, 4'd10, 3'd5, 4'd14, 1'b0, 1'b0};
    tbl[6] = '{4'd12, 4'd10, 3'd7, 4'd9,  1'b0, 1'b0};
    tbl[7] = '{4'd3,  4'd5,  3'd3, 4'd10, 1'b0, 1'b0};
    tbl[8] = '{4'd7,  4'd7,  3'd1, 4'd0,  1'b0, 1'b0};
    tbl[9] = '{4'd15, 4'd1,  3'd0, 4'd0,  1'b1, 1'b0};

    reset = 1'b1; go = 1'b0; data = 4'd0; opcode = 3'd0;
    m_res = 4'd0; m_c = 1'b0; m_b = 1'b0;
    cyc(3);
    chk("rst_leds", {led_idle, led_wait, led_rdy, led_done}, 4'b1000);
    chk("rst_regs", {alu_a, alu_b, alu_op, result, cout, borrow}, 17'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    cyc(2);

    // Short glitch must not pass the debouncer
    data = 4'd5; go = 1'b1;
    cyc(2);
    go = 1'b0;
    cyc(12);
    chk("glitch_idle", led_idle, 1'b1);
    chk("glitch_a", alu_a, 4'd0);

    go = 1'b1;
    cyc(6);
    go = 1'b0;
    cyc(3);
    chk("long_press_wait", led_wait, 1'b1);
    chk("long_press_a", alu_a, 4'd5);
    cyc(10);
    chk("in_wait_b", {led_wait, alu_a}, {1'b1, 4'd5});

    // Asynchronous reset in WAIT_B, checked between clock edges
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("async_rst_led", led_idle, 1'b1);
    chk("async_rst_a", alu_a, 4'd0);
    chk("async_rst_res", result, 4'd0);
    cyc(1);
    reset = 1'b0;
    cyc(2);

    for (int i = 0; i < 10; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].res, tbl[i].c, tbl[i].bw);

    run_op(4'd12, 4'd10, 3'd6, 4'd6, 1'b0, 1'b0);
    opcode = 3'd7; data = 4'd15;
    cyc(6);
    chk("done_opchg_res", result, 4'd6);
    chk("done_opchg_op", alu_op, 3'd6);
    chk("done_opchg_led", led_done, 1'b1);

    run_op(4'd10, 4'd0, 3'd2, 4'd5, 1'b0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      ra  = 4'($urandom);
      rb  = 4'($urandom);
      rop = 3'($urandom_range(7, 0));
      e   = ref_alu(ra, rb, rop);
      run_op(ra, rb, rop, e[3:0], e[4], e[5]);
    end

    // Reset after completed operations clears held results too
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("final_rst", {led_idle, alu_a, alu_b, alu_op, result, cout, borrow}, {1'b1, 17'd0});
    cyc(1);
    reset = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
